// File: rtl/cla_pipe_addsub.sv
// ---------------------------------------------------------------------------
// cla_pipe_addsub
//   Three-stage pipelined two-level carry-lookahead adder/subtractor with
//   valid/ready flow control. First-level lookahead works on GROUP-bit
//   groups; a second-level lookahead across the group generate/propagate
//   terms produces every group carry-in directly from c0.
//
//   S1: register g = a & b', p = a ^ b', c0   (b' = ~b and c0 = 1 when sub)
//   S2: group G/P, group carry-ins C_j        (registered with g, p)
//   S3: in-group carries, sum, cout, ovf, zero (registered outputs)
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready input handshake; in_ready is combinational from out_ready
//   a, b, cin, sub    operands; cin is ignored when sub=1 (a - b = a + ~b + 1)
//   out_valid/out_ready output handshake
//   sum, cout, ovf, zero  result, carry out (sub: 1 = no borrow),
//                     signed overflow, sum == 0
// ---------------------------------------------------------------------------
module cla_pipe_addsub #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned GROUP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int unsigned NGRP = WIDTH / GROUP;
   // Common vector width for the lookahead function (in-group and across-group use)
   localparam int unsigned LAW  = (NGRP > GROUP) ? NGRP : GROUP;

   // Lookahead carry into position n of a generate/propagate vector:
   //   c_n = OR_k<n ( g_k & AND_k<m<n p_m ) | ( AND_m<n p_m ) & ci
   // Written as a flat sum of products so each carry is an independent term.
   function automatic logic la_carry(input logic [LAW-1:0] gv,
                                     input logic [LAW-1:0] pv,
                                     input logic           ci,
                                     input int unsigned    n);
      logic c;
      logic t;
      c = 1'b0;
      for (int unsigned k = 0; k < LAW; k++) begin
         t = gv[k] & (k < n);
         for (int unsigned m = k + 1; m < LAW; m++) begin
            if (m < n) t = t & pv[m];
         end
         c = c | t;
      end
      t = ci;
      for (int unsigned m = 0; m < LAW; m++) begin
         if (m < n) t = t & pv[m];
      end
      return c | t;
   endfunction

   // ------------------------------------------------------------------
   // Flow control: a stage advances when the stage after it can take data
   // or when it holds a bubble, so bubbles collapse during output stalls.
   // ------------------------------------------------------------------
   logic v1_q, v2_q, v3_q;
   logic adv1_c, adv2_c, adv3_c;

   always_comb begin
      adv3_c = out_ready | ~v3_q;
      adv2_c = adv3_c | ~v2_q;
      adv1_c = adv2_c | ~v1_q;
   end

   assign in_ready  = adv1_c;
   assign out_valid = v3_q;

   // ------------------------------------------------------------------
   // Stage 1: operand conditioning and bitwise generate/propagate
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] bx_d;
   logic [WIDTH-1:0] g1_d, p1_d;
   logic             c01_d;
   logic [WIDTH-1:0] g1_q, p1_q;
   logic             c01_q;

   always_comb begin
      bx_d  = sub ? ~b : b;
      g1_d  = a & bx_d;
      p1_d  = a ^ bx_d;
      c01_d = sub | cin;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q  <= 1'b0;
         g1_q  <= '0;
         p1_q  <= '0;
         c01_q <= 1'b0;
      end else if (adv1_c) begin
         v1_q <= in_valid;
         if (in_valid) begin
            g1_q  <= g1_d;
            p1_q  <= p1_d;
            c01_q <= c01_d;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: group generate/propagate and second-level group carry-ins
   // ------------------------------------------------------------------
   logic [NGRP-1:0]  gg_d, pg_d, cg_d;
   logic [WIDTH-1:0] g2_q, p2_q;
   logic [NGRP-1:0]  gg2_q, pg2_q, cg2_q;

   always_comb begin : s2_lookahead
      logic [LAW-1:0] gs;
      logic [LAW-1:0] ps;
      gs   = '0;
      ps   = '0;
      gg_d = '0;
      pg_d = '0;
      cg_d = '0;
      for (int unsigned j = 0; j < NGRP; j++) begin
         gs      = LAW'(g1_q[j*GROUP +: GROUP]);
         ps      = LAW'(p1_q[j*GROUP +: GROUP]);
         // Group generate is the carry out of the group with zero carry-in
         gg_d[j] = la_carry(gs, ps, 1'b0, GROUP);
         pg_d[j] = &p1_q[j*GROUP +: GROUP];
      end
      // C_0 = c0; every other C_j is a flat term of c0 and lower G/P
      for (int unsigned j = 0; j < NGRP; j++) begin
         cg_d[j] = la_carry(LAW'(gg_d), LAW'(pg_d), c01_q, j);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2_q  <= 1'b0;
         g2_q  <= '0;
         p2_q  <= '0;
         gg2_q <= '0;
         pg2_q <= '0;
         cg2_q <= '0;
      end else if (adv2_c) begin
         v2_q <= v1_q;
         if (v1_q) begin
            g2_q  <= g1_q;
            p2_q  <= p1_q;
            gg2_q <= gg_d;
            pg2_q <= pg_d;
            cg2_q <= cg_d;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 3: in-group carries, sum and flags
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] c_d;
   logic [WIDTH-1:0] sum_d;
   logic             cout_d, ovf_d, zero_d;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q, ovf_q, zero_q;

   always_comb begin : s3_carries
      logic [LAW-1:0] gs;
      logic [LAW-1:0] ps;
      gs  = '0;
      ps  = '0;
      c_d = '0;
      for (int unsigned j = 0; j < NGRP; j++) begin
         gs = LAW'(g2_q[j*GROUP +: GROUP]);
         ps = LAW'(p2_q[j*GROUP +: GROUP]);
         for (int unsigned i = 0; i < GROUP; i++) begin
            c_d[j*GROUP + i] = la_carry(gs, ps, cg2_q[j], i);
         end
      end
      sum_d  = p2_q ^ c_d;
      cout_d = gg2_q[NGRP-1] | (pg2_q[NGRP-1] & cg2_q[NGRP-1]);
      // Signed overflow: carry into the MSB differs from carry out of it
      ovf_d  = c_d[WIDTH-1] ^ cout_d;
      zero_d = ~|sum_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v3_q   <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (adv3_c) begin
         v3_q <= v2_q;
         if (v2_q) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
         end
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;

endmodule
